// File: rtl/btn_step_ctrl_if.sv
// Button/step bundle between the raw push-buttons and the step controller.
// The master side owns the raw buttons; the slave side (controller) owns the step outputs.
interface btn_step_if;
  logic btn_inc_raw;
  logic btn_dec_raw;
  logic inc;
  logic dec;
  logic locked;

  modport master (
    output btn_inc_raw,
    output btn_dec_raw,
    input  inc,
    input  dec,
    input  locked
  );

  modport slave (
    input  btn_inc_raw,
    input  btn_dec_raw,
    output inc,
    output dec,
    output locked
  );
endinterface

// File: rtl/btn_step_ctrl.sv
// Two-button step controller: synchronize, debounce, then emit single-cycle inc/dec
// pulses with hold-to-repeat. Pressing both buttons locks out until both are released.
module btn_step_ctrl #(
  parameter int unsigned DB_CYCLES  = 4,
  parameter int unsigned RPT_DELAY  = 16,
  parameter int unsigned RPT_PERIOD = 4
) (
  input  logic      clk_in,
  input  logic      rst,
  btn_step_if.slave bus
);

  localparam logic [15:0] DB_TC    = 16'(DB_CYCLES);
  localparam logic [15:0] DELAY_TC = 16'(RPT_DELAY - 1);
  localparam logic [15:0] PER_TC   = 16'(RPT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} state_t;

  // Channel 0 is increment, channel 1 is decrement.
  logic [1:0] raw;
  logic [1:0] deb;

  assign raw = {bus.btn_dec_raw, bus.btn_inc_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_db
      logic        meta_reg;
      logic        sync_reg;
      logic        deb_reg;
      logic [15:0] cnt_reg;

      always_ff @(posedge clk_in) begin
        if (rst) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
          deb_reg  <= 1'b0;
          cnt_reg  <= '0;
        end else begin
          meta_reg <= raw[gi];
          sync_reg <= meta_reg;
          // Level must differ from the debounced value for DB_CYCLES counted cycles.
          if (sync_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_TC) begin
            deb_reg <= sync_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
      end

      assign deb[gi] = deb_reg;
    end
  endgenerate

  state_t      state_reg;
  logic        dir_reg;
  logic [15:0] rpt_cnt_reg;
  logic        inc_reg;
  logic        dec_reg;
  logic        locked_reg;

  logic deb_inc;
  logic deb_dec;
  logic active;
  logic opposite;

  assign deb_inc  = deb[0];
  assign deb_dec  = deb[1];
  assign active   = dir_reg ? deb_inc : deb_dec;
  assign opposite = dir_reg ? deb_dec : deb_inc;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_reg   <= IDLE;
      dir_reg     <= 1'b0;
      rpt_cnt_reg <= '0;
      inc_reg     <= 1'b0;
      dec_reg     <= 1'b0;
      locked_reg  <= 1'b0;
    end else begin
      inc_reg <= 1'b0;
      dec_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (deb_inc && deb_dec) begin
            state_reg  <= LOCK;
            locked_reg <= 1'b1;
          end else if (deb_inc || deb_dec) begin
            inc_reg     <= deb_inc;
            dec_reg     <= deb_dec;
            dir_reg     <= deb_inc;
            rpt_cnt_reg <= '0;
            state_reg   <= DELAY;
          end
        end
        DELAY, REPEAT: begin
          // Opposite press beats release, which beats the terminal count.
          if (opposite) begin
            state_reg  <= LOCK;
            locked_reg <= 1'b1;
          end else if (!active) begin
            state_reg <= IDLE;
          end else if (rpt_cnt_reg == ((state_reg == DELAY) ? DELAY_TC : PER_TC)) begin
            inc_reg     <= dir_reg;
            dec_reg     <= !dir_reg;
            rpt_cnt_reg <= '0;
            state_reg   <= REPEAT;
          end else begin
            rpt_cnt_reg <= rpt_cnt_reg + 16'd1;
          end
        end
        LOCK: begin
          if (!deb_inc && !deb_dec) begin
            state_reg  <= IDLE;
            locked_reg <= 1'b0;
          end
        end
        default: begin
          state_reg  <= IDLE;
          locked_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.inc    = inc_reg;
  assign bus.dec    = dec_reg;
  assign bus.locked = locked_reg;

endmodule

// File: tb/tb_btn_step_ctrl.sv
// Scoreboard bench for btn_step_ctrl at default parameters: expected pulses are queued
// with their edge index; a negedge monitor pops and compares every pulse it sees.
module tb_btn_step_ctrl;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  int   edge_cnt = 0;

  btn_step_if bus ();

  btn_step_ctrl #(.DB_CYCLES(4), .RPT_DELAY(16), .RPT_PERIOD(4)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // Index of the next rising edge, as seen from any negedge.
  always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int   e;
    logic up;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   pulse_cnt = 0;

  task automatic expect_pulse(input int e, input logic up);
    exp_t x;
    x.e  = e;
    x.up = up;
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", name, act, req, edge_cnt);
    end else begin
      $display("ok   %s: %0d (edge %0d)", name, act, edge_cnt);
    end
  endtask

  task automatic wait_edge(input int e);
    while (edge_cnt < e) @(negedge clk_in);
  endtask

  // Monitor: every observed pulse is matched against the head of the queue.
  always @(negedge clk_in) begin
    if (bus.inc || bus.dec) begin
      exp_t x;
      pulse_cnt++;
      checks++;
      if (bus.inc && bus.dec) begin
        errors++;
        $display("FAIL both_pulses: inc=1 dec=1 at edge %0d, want at most one", edge_cnt - 1);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: %s at edge %0d, want none", bus.inc ? "inc" : "dec", edge_cnt - 1);
      end else begin
        x = exp_q.pop_front();
        if (x.e != edge_cnt - 1 || x.up != bus.inc) begin
          errors++;
          $display("FAIL pulse: %s at edge %0d, want %s at edge %0d",
                   bus.inc ? "inc" : "dec", edge_cnt - 1, x.up ? "inc" : "dec", x.e);
        end else begin
          $display("ok   pulse: %s at edge %0d", bus.inc ? "inc" : "dec", edge_cnt - 1);
        end
      end
    end
  end

  task automatic settle(input string name, input int p0, input int want);
    int budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk_in);
      budget--;
    end
    repeat (12) @(negedge clk_in);
    chk({name, "_queue_left"}, exp_q.size(), 0);
    chk({name, "_pulses"}, pulse_cnt - p0, want);
    exp_q.delete();
  endtask

  initial begin
    int t0;
    int p0;
    bus.btn_inc_raw = 1'b1;
    bus.btn_dec_raw = 1'b1;
    rst = 1'b1;

    // Reset with both buttons held, then inc held through deassertion.
    @(negedge clk_in);
    @(negedge clk_in);
    @(negedge clk_in);
    chk("rst_inc", int'(bus.inc), 0);
    chk("rst_dec", int'(bus.dec), 0);
    chk("rst_locked", int'(bus.locked), 0);
    p0 = pulse_cnt;
    t0 = edge_cnt;
    rst = 1'b0;
    bus.btn_dec_raw = 1'b0;
    expect_pulse(t0 + 7, 1'b1);
    wait_edge(t0 + 10);
    bus.btn_inc_raw = 1'b0;
    settle("held_through_reset", p0, 1);

    // Bounce of 3 cycles must not register.
    p0 = pulse_cnt;
    t0 = edge_cnt;
    bus.btn_inc_raw = 1'b1;
    wait_edge(t0 + 3);
    bus.btn_inc_raw = 1'b0;
    wait_edge(t0 + 13);
    settle("bounce", p0, 0);

    // Inc held 40 cycles: delay then auto-repeat, ends on debounced release.
    p0 = pulse_cnt;
    t0 = edge_cnt;
    bus.btn_inc_raw = 1'b1;
    expect_pulse(t0 + 7, 1'b1);
    for (int i = 0; i < 6; i++) expect_pulse(t0 + 23 + 4 * i, 1'b1);
    wait_edge(t0 + 40);
    bus.btn_inc_raw = 1'b0;
    settle("inc_repeat", p0, 7);

    // Dec released 5 cycles after its first pulse: single pulse.
    p0 = pulse_cnt;
    t0 = edge_cnt;
    bus.btn_dec_raw = 1'b1;
    expect_pulse(t0 + 7, 1'b0);
    wait_edge(t0 + 12);
    bus.btn_dec_raw = 1'b0;
    settle("dec_single", p0, 1);

    // Inc into repeat, then dec pressed: lockout until both released.
    p0 = pulse_cnt;
    t0 = edge_cnt;
    bus.btn_inc_raw = 1'b1;
    expect_pulse(t0 + 7, 1'b1);
    expect_pulse(t0 + 23, 1'b1);
    expect_pulse(t0 + 27, 1'b1);
    expect_pulse(t0 + 31, 1'b1);
    wait_edge(t0 + 25);
    bus.btn_dec_raw = 1'b1;
    wait_edge(t0 + 32);
    chk("lock_before", int'(bus.locked), 0);
    wait_edge(t0 + 33);
    chk("lock_set", int'(bus.locked), 1);
    wait_edge(t0 + 45);
    chk("lock_hold", int'(bus.locked), 1);
    bus.btn_dec_raw = 1'b0;
    wait_edge(t0 + 55);
    chk("lock_one_released", int'(bus.locked), 1);
    bus.btn_inc_raw = 1'b0;
    wait_edge(t0 + 62);
    chk("lock_last_cycle", int'(bus.locked), 1);
    wait_edge(t0 + 63);
    chk("lock_cleared", int'(bus.locked), 0);
    settle("lockout", p0, 4);

    // One-cycle reset during repeat: abort, then a fresh press sequence.
    p0 = pulse_cnt;
    t0 = edge_cnt;
    bus.btn_inc_raw = 1'b1;
    expect_pulse(t0 + 7, 1'b1);
    expect_pulse(t0 + 23, 1'b1);
    expect_pulse(t0 + 27, 1'b1);
    wait_edge(t0 + 29);
    rst = 1'b1;
    wait_edge(t0 + 30);
    rst = 1'b0;
    chk("abort_inc", int'(bus.inc), 0);
    chk("abort_locked", int'(bus.locked), 0);
    expect_pulse(t0 + 37, 1'b1);
    expect_pulse(t0 + 53, 1'b1);
    // Release lands its debounced fall on the terminal-count cycle at t0+57.
    wait_edge(t0 + 50);
    bus.btn_inc_raw = 1'b0;
    settle("reset_repeat", p0, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: edge %0d reached, want finish earlier", edge_cnt);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/btn_step_ctrl.md
BTN_STEP_CTRL -- requirements
Module: btn_step_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 4: consecutive stable cycles required before a debounced level changes; legal range 2..65535.
REQ-002 Parameter RPT_DELAY, default 16: cycles from the first pulse to the first auto-repeat pulse; legal range 2..65535.
REQ-003 Parameter RPT_PERIOD, default 4: cycles between consecutive auto-repeat pulses; legal range 2..65535.
REQ-004 Port clk_in  input  1: single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1: reset, synchronous, active-high.
REQ-006 Port btn_inc_raw  input  1: raw increment button, asynchronous, active-high, may bounce.
REQ-007 Port btn_dec_raw  input  1: raw decrement button, asynchronous, active-high, may bounce.
REQ-008 Port inc  output  1: registered one-cycle step-up pulse; drives the divider's inc input.
REQ-009 Port dec  output  1: registered one-cycle step-down pulse; drives the divider's dec input.
REQ-010 Port locked  output  1: registered; high while both buttons are debounced-pressed or a lockout awaits release.

Function
REQ-011 Each raw input SHALL pass through its own 2-flop synchronizer before any other logic.
REQ-012 Each synchronized input SHALL have a 16-bit stability counter; it clears on any change of the synchronized value versus the debounced value, and the debounced value takes the synchronized value when the counter reaches DB_CYCLES.
REQ-013 A bounce shorter than DB_CYCLES cycles SHALL never change a debounced value.
REQ-014 The FSM SHALL have states IDLE, DELAY, REPEAT and LOCK, plus a registered direction bit (up/down) that is valid in DELAY and REPEAT.
REQ-015 IDLE: exactly one debounced button pressed -> 1-cycle pulse on the matching output, store the direction, clear the 16-bit repeat counter, go to DELAY.
REQ-016 IDLE: both debounced pressed in the same cycle -> LOCK, no pulse.
REQ-017 DELAY: the counter increments each cycle; at count RPT_DELAY-1 -> pulse, clear the counter, go to REPEAT.
REQ-018 REPEAT: the counter increments each cycle; at count RPT_PERIOD-1 -> pulse, clear the counter, stay in REPEAT.
REQ-019 DELAY or REPEAT: the active debounced button releases -> IDLE with no pulse that cycle; release takes priority over a coincident terminal count.
REQ-020 DELAY or REPEAT: the opposite debounced button presses -> LOCK with no pulse that cycle; this takes priority over terminal count and release.
REQ-021 LOCK: no pulses; go to IDLE only once both debounced values are 0.
REQ-022 inc and dec SHALL never be high in the same cycle; each pulse lasts exactly one cycle.
REQ-023 locked SHALL be high exactly while the state is LOCK.
REQ-024 Latency: the first inc/dec pulse is high in the cycle starting DB_CYCLES+3 rising edges after the first edge at which the clean raw level is sampled high (2 synchronizer edges + DB_CYCLES + 1 FSM edge).
REQ-025 Repeat counters SHALL not wrap: the terminal compare clears them before overflow for every legal parameter.

Reset
REQ-026 While rst is high at a rising edge: synchronizers, debounced values and all counters clear; state becomes IDLE; inc=0, dec=0, locked=0 from the next cycle.
REQ-027 Reset mid-operation (any state) SHALL abort immediately, with no pulse in the cycle after the reset edge.
REQ-028 A button held through reset deassertion SHALL be treated as a new press: full debounce, then the first pulse at the REQ-024 latency, measured from the first non-reset edge.

Verification (defaults DB_CYCLES=4, RPT_DELAY=16, RPT_PERIOD=4)
REQ-029 rst=1 for 2 cycles with both buttons high -> inc=dec=locked=0; after rst drops with btn_inc_raw still high and btn_dec_raw low -> first inc pulse 7 edges later.
REQ-030 btn_inc_raw high 3 cycles, then low for 10 cycles -> no inc or dec pulse at any time.
REQ-031 btn_inc_raw held 40 cycles from edge 0 -> inc pulses at edges 7, 23, 27, 31, 35, 39, 43 (still held through debounce), then none after the debounced release; dec stays 0.
REQ-032 btn_dec_raw held; release 5 cycles after the first dec pulse -> exactly one dec pulse total.
REQ-033 btn_inc_raw held into REPEAT, then btn_dec_raw pressed -> after the dec debounce, locked=1 and pulses stop; locked=0 only after both buttons have been released and debounced.
REQ-034 rst asserted for 1 cycle during REPEAT with btn_inc_raw held -> no inc in the following cycle, then a fresh first pulse 7 edges after rst deasserts, then a second pulse 16 cycles later.
